// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency/period meter.
// Board defaults assume a 50 MHz system clock.
package freq_meter_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int GATE_CYCLES_DEF = CLK_HZ;

  typedef logic [1:0] per_state_t;

  localparam per_state_t ST_IDLE    = 2'd0;
  localparam per_state_t ST_ARMED   = 2'd1;
  localparam per_state_t ST_MEASURE = 2'd2;

  // Unsigned a+b clamped to lim; callers zero-extend narrower operands.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) return lim;
    else                   return sum[31:0];
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchroniser plus history flop for an asynchronous pin.
// rise is a one-cycle pulse on each synchronised rising edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~hist;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: rising edges per gate window and clk cycles per input period,
// with a sticky timeout when no edge arrives within the period counter range.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = 26,
  parameter int PER_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);
  // Last per_cnt value that still leaves room for per_cnt+1 in PER_W bits.
  localparam logic [PER_W-1:0]  PER_LIMIT = {{(PER_W-1){1'b1}}, 1'b0};

  logic              sig_level;
  logic              sig_rise;
  logic              sig_edge;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_next;
  logic [PER_W-1:0]  per_cnt;
  per_state_t        state;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .level (sig_level),
    .rise  (sig_rise)
  );

  assign sig_edge  = sig_rise & sig_level;
  assign edge_next = CNT_W'(sat_add(32'(edge_cnt), {31'd0, sig_edge}, 32'(CNT_MAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      per_cnt      <= '0;
      state        <= ST_IDLE;
      freq_count   <= '0;
      freq_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else if (!en) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      per_cnt      <= '0;
      state        <= ST_IDLE;
      freq_valid   <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      freq_valid   <= 1'b0;
      period_valid <= 1'b0;

      // An edge on the terminal cycle belongs to the window that is closing.
      if (gate_cnt == GATE_LAST) begin
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        freq_count <= edge_next;
        freq_valid <= 1'b1;
      end else begin
        gate_cnt <= gate_cnt + GATE_ONE;
        edge_cnt <= edge_next;
      end

      case (state)
        ST_IDLE: state <= ST_ARMED;
        ST_ARMED: begin
          if (sig_edge) begin
            state   <= ST_MEASURE;
            per_cnt <= '0;
          end
        end
        ST_MEASURE: begin
          if (sig_edge) begin
            period       <= per_cnt + PER_ONE;
            period_valid <= 1'b1;
            timeout      <= 1'b0;
            per_cnt      <= '0;
          end else if (per_cnt == PER_LIMIT) begin
            timeout <= 1'b1;
            state   <= ST_ARMED;
            per_cnt <= '0;
          end else begin
            per_cnt <= per_cnt + PER_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
